// File: rtl/key_exp_ctrl.sv
// key_exp_ctrl -- AES key-expansion sequencer for 128/192/256-bit keys.
//
// Loads the cipher key words into round-key memory, then produces each further
// word from a rolling history of the last Nk words. Words that need SubWord are
// issued to an external S-box with a fixed one-cycle read latency. The result
// is consumed in the following cycle.
//
// Ports
//   clk_in           clock, rising edge
//   rst_in           asynchronous active-low reset
//   start_in         expansion request, sampled in IDLE only
//   conf_in[1:0]     key size: 00=128, 01=192, 10=256, 11 reserved (ignored)
//   key_in[255:0]    cipher key, w0 in bits [255:224]
//   busy_out         expansion in progress (LOAD/GEN/SUB)
//   done_out         one-cycle pulse after the last word is written
//   sbox_en_out      S-box lookup request
//   sbox_data_out    word to substitute, w[i-1]
//   sbox_conf_out    key size captured at start
//   rcon_out         current round constant
//   sbox_data_in     SubWord(RotWord(w)) ^ {rcon,24'h0}, one cycle after request
//   sbox_data256_in  SubWord(w), one cycle after request
//   rk_we_out        round-key write strobe
//   rk_addr_out      round-key word index
//   rk_data_out      round-key word
module key_exp_ctrl (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [1:0]   conf_in,
  input  logic [255:0] key_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         sbox_en_out,
  output logic [31:0]  sbox_data_out,
  output logic [1:0]   sbox_conf_out,
  output logic [7:0]   rcon_out,
  input  logic [31:0]  sbox_data_in,
  input  logic [31:0]  sbox_data256_in,
  output logic         rk_we_out,
  output logic [5:0]   rk_addr_out,
  output logic [31:0]  rk_data_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    GEN  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    idx;        // word index i
  logic [2:0]    phase;      // i mod Nk, kept as a wrapping counter
  logic [7:0]    rcon;
  logic [1:0]    conf_q;
  logic [255:0]  key_sh;     // captured key, shifted up one word per LOAD write
  logic [31:0]   hist [8];   // hist[0] = w[i-1], hist[Nk-1] = w[i-Nk]

  logic [2:0]    nk_m1;
  logic [5:0]    last_idx;
  logic          need_sub;
  logic          start_ok;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          sb_en;
  logic [31:0]   sb_data;

  // GF(2^8) multiply-by-x used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  always_comb begin
    unique case (conf_q)
      2'b00:   begin nk_m1 = 3'd3; last_idx = 6'd43; end
      2'b01:   begin nk_m1 = 3'd5; last_idx = 6'd51; end
      default: begin nk_m1 = 3'd7; last_idx = 6'd59; end
    endcase
  end

  // 256-bit keys also substitute the word half-way through each group.
  assign need_sub = (phase == 3'd0) || (conf_q == 2'b10 && phase == 3'd4);
  assign start_ok = start_in && (conf_in != 2'b11);

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_ok) state_nxt = LOAD;
      LOAD: if (idx == {3'd0, nk_m1}) state_nxt = GEN;
      GEN: begin
        if (need_sub)              state_nxt = SUB;
        else if (idx == last_idx)  state_nxt = DONE;
      end
      SUB:  state_nxt = (idx == last_idx) ? DONE : GEN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_out = 1'b0;
    done_out = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 32'h0;
    sb_en    = 1'b0;
    sb_data  = 32'h0;
    unique case (state)
      LOAD: begin
        busy_out = 1'b1;
        wr_en    = 1'b1;
        wr_data  = key_sh[255:224];
      end
      GEN: begin
        busy_out = 1'b1;
        if (need_sub) begin
          sb_en   = 1'b1;
          sb_data = hist[0];
        end else begin
          wr_en   = 1'b1;
          wr_data = hist[nk_m1] ^ hist[0];
        end
      end
      SUB: begin
        busy_out = 1'b1;
        wr_en    = 1'b1;
        wr_data  = hist[nk_m1] ^ ((phase == 3'd0) ? sbox_data_in : sbox_data256_in);
      end
      DONE: done_out = 1'b1;
      default: ;
    endcase
  end

  // Address and data are only driven while writing, so the index never shows
  // its post-final value on the bus.
  assign rk_we_out     = wr_en;
  assign rk_addr_out   = wr_en ? idx : 6'd0;
  assign rk_data_out   = wr_data;
  assign sbox_en_out   = sb_en;
  assign sbox_data_out = sb_data;
  assign sbox_conf_out = conf_q;
  assign rcon_out      = rcon;

  // Index, phase, round constant and history update on each write
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx    <= 6'd0;
      phase  <= 3'd0;
      rcon   <= 8'h01;
      conf_q <= 2'b00;
      for (int k = 0; k < 8; k++) hist[k] <= 32'h0;
    end else if (state == IDLE && start_ok) begin
      idx    <= 6'd0;
      phase  <= 3'd0;
      rcon   <= 8'h01;
      conf_q <= conf_in;
    end else if (wr_en) begin
      idx   <= idx + 6'd1;
      phase <= (phase == nk_m1) ? 3'd0 : phase + 3'd1;
      for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= wr_data;
      // Only SUB writes with phase 0 are the rcon-consuming words (i >= Nk).
      if (state == SUB && phase == 3'd0) rcon <= xtime(rcon);
    end
  end

  // Key capture; pure data, no reset needed
  always_ff @(posedge clk_in) begin
    if (state == IDLE && start_ok) key_sh <= key_in;
    else if (state == LOAD)        key_sh <= {key_sh[223:0], 32'h0};
  end

endmodule

// File: doc/key_exp_ctrl.md
KEY_EXP_CTRL -- requirements
Module: key_exp_ctrl

Interface
REQ-001 The block SHALL have no parameters; S-box read latency is fixed at 1 clock.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk_in  in  1  single clock; all flops on rising edge
- rst_in  in  1  reset; asynchronous assert, active-low (0 = reset)
- start_in  in  1  expansion request, sampled in IDLE only
- conf_in  in  2  key size: 00=128 (Nk=4), 01=192 (Nk=6), 10=256 (Nk=8), 11 reserved
- key_in  in  256  cipher key; bits [255:224] = w0, then w1..; only top Nk words used
- busy_out  out  1  high from the cycle after an accepted start until done_out
- done_out  out  1  one-cycle pulse after the last round-key word is written
- sbox_en_out  out  1  S-box lookup enable
- sbox_data_out  out  32  word to substitute, = w[i-1]
- sbox_conf_out  out  2  registered copy of conf_in captured at start
- rcon_out  out  8  current round constant
- sbox_data_in  in  32  SubWord(RotWord(word)) with rcon XORed into the MSB, valid 1 cycle after sbox_en_out
- sbox_data256_in  in  32  SubWord(word) without rotation, valid 1 cycle after sbox_en_out
- rk_we_out  out  1  round-key memory write strobe
- rk_addr_out  out  6  word index i, 0..Nr*4+3
- rk_data_out  out  32  word w[i]

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, GEN, SUB and DONE.
REQ-004 In IDLE, start_in=1 with conf_in!=11 SHALL capture conf_in and key_in, set i=0, set rcon=01 and go to LOAD; start_in with conf_in=11 SHALL be ignored.
REQ-005 start_in SHALL be ignored in every state other than IDLE.
REQ-006 LOAD SHALL write one key word per cycle, w0..w(Nk-1), at addresses 0..Nk-1; after word Nk-1 the FSM SHALL go to GEN.
REQ-007 The block SHALL hold the last Nk words in an 8x32 history register, from which w[i-1] and w[i-Nk] are read.
REQ-008 In GEN with i mod Nk == 0 the block SHALL assert sbox_en_out with sbox_data_out = w[i-1] and go to SUB.
REQ-009 In GEN with Nk=8 and i mod 8 == 4 the block SHALL likewise assert sbox_en_out and go to SUB.
REQ-010 In GEN in all other cases the block SHALL write w[i] = w[i-Nk] ^ w[i-1] in the same cycle.
REQ-011 In SUB the block SHALL write w[i] = w[i-Nk] ^ sbox_data_in when i mod Nk == 0, and w[i] = w[i-Nk] ^ sbox_data256_in otherwise, then return to GEN.
REQ-012 After each write with i mod Nk == 0 (i >= Nk), rcon SHALL update by xtime: rcon<<1, XOR 1B if bit 7 was set. The sequence SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-013 rcon_out SHALL be held stable from the GEN issue cycle through the SUB cycle.
REQ-014 Each write SHALL increment i; the write of index 43 (128), 51 (192) or 59 (256) SHALL move the FSM to DONE.
REQ-015 DONE SHALL pulse done_out for exactly one cycle and return to IDLE; busy_out SHALL be 0 in that cycle.
REQ-016 Start is accepted in cycle 0; done_out SHALL be high in cycle 55 for 128, cycle 61 for 192 and cycle 74 for 256.
REQ-017 rk_we_out SHALL be high exactly once per word; no address SHALL be written twice; rk_addr_out SHALL never exceed 59.
REQ-018 sbox_en_out SHALL be 0 outside GEN issue cycles.

Reset
REQ-019 While rst_in=0 the block SHALL be in IDLE, with busy_out, done_out, sbox_en_out and rk_we_out at 0, and rk_addr_out, rk_data_out, sbox_data_out, sbox_conf_out and the history register at 0, i=0 and rcon_out=01.
REQ-020 Reset asserted mid-expansion SHALL abort immediately, with no further writes and no done pulse; the first start after release SHALL run a complete expansion.

Verification
REQ-021 128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> w4=a0fafe17, w43=b6630ca6, done_out in cycle 55, 44 writes.
REQ-022 192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w51=01002202, done_out in cycle 61, 52 writes.
REQ-023 256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w59=706c631e, 13 sbox_en_out pulses, done_out in cycle 74.
REQ-024 start_in with conf_in=11 -> stays IDLE, busy_out=0, no writes; start_in pulsed mid-run -> no effect on timing or data.
REQ-025 rst_in low at cycle 20 of a 256 run -> all outputs 0 next edge; a new 128 start after release -> REQ-021 results.
REQ-026 Over every run, the sampled rcon_out sequence SHALL match REQ-012, truncated to 10/8/7 values for 128/192/256.
